// File: rtl/dsp38_pkg.sv
// ----------------------------------------------------------------------------
// dsp38_pkg
// Shared definitions for logic that drives a DSP38 hard block.
//   * DSP38 port widths (A, B, Z, SHIFT_RIGHT, FEEDBACK)
//   * FEEDBACK pin encoding used by the MAC sequencer
//   * FSM state encoding for dsp38_mac_sequencer
//   * width of the pipeline-latency counter (DSP_LATENCY is 1..4)
// ----------------------------------------------------------------------------
package dsp38_pkg;

    localparam int DSP38_A_W     = 20;
    localparam int DSP38_B_W     = 18;
    localparam int DSP38_Z_W     = 38;
    localparam int DSP38_SHIFT_W = 6;
    localparam int DSP38_FB_W    = 3;
    localparam int LAT_CNT_W     = 3;

    // FEEDBACK selects what the DSP38 adds the product to. The sequencer
    // only ever accumulates onto its own Z register; LOAD_ACC handles
    // restarting the sum.
    typedef enum logic [DSP38_FB_W-1:0] {
        FB_ACCUMULATE = 3'b000
    } dsp38Feedback_e;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } seqState_e;

endpackage

// File: rtl/dsp38_lat_cnt.sv
// ----------------------------------------------------------------------------
// dsp38_lat_cnt
// Loadable down-counter used to wait out the DSP38 pipeline.
// Ports:
//   clk_i      clock, rising edge
//   rst_ni     asynchronous active-low reset (count cleared)
//   load_i     load loadVal_i (has priority over en_i)
//   loadVal_i  value to load
//   en_i       decrement by one while non-zero
//   zero_o     count is zero
// ----------------------------------------------------------------------------
module dsp38_lat_cnt
    import dsp38_pkg::*;
#(
    parameter int WIDTH = LAT_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] loadVal_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Load wins over decrement; the count saturates at zero so a lingering
    // enable cannot wrap it around.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = loadVal_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dsp38_mac_sequencer.sv
// ----------------------------------------------------------------------------
// dsp38_mac_sequencer
// Control stage in front of a DSP38 in multiply-accumulate mode. Operand
// pairs arrive on a valid/ready stream; every NUM_TAPS pairs form one dot
// product. The block drives the DSP38 operand/control pins, waits out the
// DSP pipeline, captures Z and offers it on a valid/ready result stream.
// Ports:
//   CLK, RESET            clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready       operand stream handshake
//   s_a, s_b, s_sub       multiplicand, multiplier, subtract-this-product
//   m_valid/m_ready       result stream handshake
//   m_z                   dot-product result (dsp_z bit-for-bit)
//   busy                  group in progress (first accept .. result taken)
//   dsp_a, dsp_b          DSP38 A/B operands
//   dsp_load_acc          DSP38 LOAD_ACC (first beat of a group)
//   dsp_subtract          DSP38 SUBTRACT
//   dsp_feedback          DSP38 FEEDBACK (always accumulate)
//   dsp_shift_right, dsp_round, dsp_saturate   static DSP38 settings
//   dsp_z                 DSP38 Z output
// ----------------------------------------------------------------------------
module dsp38_mac_sequencer
    import dsp38_pkg::*;
#(
    parameter int                       NUM_TAPS    = 4,
    parameter int                       DSP_LATENCY = 1,
    parameter logic [DSP38_SHIFT_W-1:0] SHIFT       = '0,
    parameter bit                       ROUND_EN    = 1'b0,
    parameter bit                       SAT_EN      = 1'b0
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DSP38_A_W-1:0]     s_a,
    input  logic [DSP38_B_W-1:0]     s_b,
    input  logic                     s_sub,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DSP38_Z_W-1:0]     m_z,
    output logic                     busy,
    output logic [DSP38_A_W-1:0]     dsp_a,
    output logic [DSP38_B_W-1:0]     dsp_b,
    output logic                     dsp_load_acc,
    output logic                     dsp_subtract,
    output logic [DSP38_FB_W-1:0]    dsp_feedback,
    output logic [DSP38_SHIFT_W-1:0] dsp_shift_right,
    output logic                     dsp_round,
    output logic                     dsp_saturate,
    input  logic [DSP38_Z_W-1:0]     dsp_z
);

    localparam int                TAP_W    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic [TAP_W-1:0]  LAST_TAP = TAP_W'(NUM_TAPS - 1);

    seqState_e              state_q;
    seqState_e              state_d;
    logic [TAP_W-1:0]       tapCnt_q;
    logic [TAP_W-1:0]       tapCnt_d;
    logic [DSP38_A_W-1:0]   dspA_q;
    logic [DSP38_B_W-1:0]   dspB_q;
    logic                   dspLoad_q;
    logic                   dspSub_q;
    logic [DSP38_Z_W-1:0]   mZ_q;
    logic                   mValid_q;
    logic                   busy_q;

    logic                   sReady;
    logic                   accept;
    logic                   lastBeat;
    logic                   latLoad;
    logic                   latZero;
    logic                   capture;
    logic                   resultTaken;

    // State register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a group of NUM_TAPS accepts, then the pipeline
    // drain, then hold the result until the consumer takes it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ACCUM: if (accept && lastBeat) state_d = ST_DRAIN;
            ST_DRAIN: if (latZero)            state_d = ST_HOLD;
            ST_HOLD:  if (resultTaken)        state_d = ST_ACCUM;
            default:                          state_d = ST_ACCUM;
        endcase
    end

    // FSM outputs. Operands are only taken in ACCUM; the latency counter is
    // armed on the last accept so DRAIN ends exactly DSP_LATENCY cycles after
    // the final operand reaches dsp_a/dsp_b.
    always_comb begin
        sReady      = (state_q == ST_ACCUM);
        accept      = sReady && s_valid;
        lastBeat    = (tapCnt_q == LAST_TAP);
        latLoad     = accept && lastBeat;
        capture     = (state_q == ST_DRAIN) && latZero;
        resultTaken = (state_q == ST_HOLD) && mValid_q && m_ready;
    end

    dsp38_lat_cnt #(
        .WIDTH (LAT_CNT_W)
    ) u_lat_cnt (
        .clk_i     (CLK),
        .rst_ni    (RESET),
        .load_i    (latLoad),
        .loadVal_i (LAT_CNT_W'(DSP_LATENCY)),
        .en_i      (state_q == ST_DRAIN),
        .zero_o    (latZero)
    );

    // Tap counter wraps to zero on the last beat so the next group starts
    // with LOAD_ACC asserted.
    always_comb begin
        tapCnt_d = tapCnt_q;
        if (accept) begin
            tapCnt_d = lastBeat ? '0 : tapCnt_q + TAP_W'(1);
        end
    end

    // DSP operand/control registers. Any cycle without an accept presents a
    // zero product with LOAD_ACC low, so the DSP accumulator is left as is.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            tapCnt_q  <= '0;
            dspA_q    <= '0;
            dspB_q    <= '0;
            dspLoad_q <= 1'b0;
            dspSub_q  <= 1'b0;
        end else begin
            tapCnt_q  <= tapCnt_d;
            dspA_q    <= accept ? s_a : '0;
            dspB_q    <= accept ? s_b : '0;
            dspLoad_q <= accept && (tapCnt_q == '0);
            dspSub_q  <= accept && s_sub;
        end
    end

    // Result capture and output handshake; busy spans from the first accept
    // of a group until its result has been taken.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mZ_q     <= '0;
            mValid_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            if (capture) begin
                mZ_q     <= dsp_z;
                mValid_q <= 1'b1;
            end else if (resultTaken) begin
                mValid_q <= 1'b0;
            end
            if (accept) begin
                busy_q <= 1'b1;
            end else if (resultTaken) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign s_ready         = sReady;
    assign m_valid         = mValid_q;
    assign m_z             = mZ_q;
    assign busy            = busy_q;
    assign dsp_a           = dspA_q;
    assign dsp_b           = dspB_q;
    assign dsp_load_acc    = dspLoad_q;
    assign dsp_subtract    = dspSub_q;
    assign dsp_feedback    = FB_ACCUMULATE;
    assign dsp_shift_right = SHIFT;
    assign dsp_round       = ROUND_EN;
    assign dsp_saturate    = SAT_EN;

endmodule

// File: tb/tb_dsp38_mac_sequencer.sv
// ----------------------------------------------------------------------------
// tb_dsp38_mac_sequencer
// Directed bench for dsp38_mac_sequencer. Two instances: u4 (NUM_TAPS=4)
// and u1 (NUM_TAPS=1), each loaded by a behavioural DSP38 in MAC mode with
// only the output register enabled (DSP_LATENCY=1).
// ----------------------------------------------------------------------------
module tb_dsp38_mac_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;

    logic        s_valid, s_ready, s_sub, m_valid, m_ready, busy;
    logic [19:0] s_a, dsp_a;
    logic [17:0] s_b, dsp_b;
    logic [37:0] m_z, dsp_z;
    logic        dsp_load_acc, dsp_subtract, dsp_round, dsp_saturate;
    logic [2:0]  dsp_feedback;
    logic [5:0]  dsp_shift_right;

    logic        u1_s_valid, u1_s_ready, u1_s_sub, u1_m_valid, u1_m_ready, u1_busy;
    logic [19:0] u1_s_a, u1_dsp_a;
    logic [17:0] u1_s_b, u1_dsp_b;
    logic [37:0] u1_m_z, u1_dsp_z;
    logic        u1_dsp_load_acc, u1_dsp_subtract, u1_dsp_round, u1_dsp_saturate;
    logic [2:0]  u1_dsp_feedback;
    logic [5:0]  u1_dsp_shift_right;

    int nVec = 0;
    int nErr = 0;

    // 100 MHz clock.
    always #5 CLK = ~CLK;

    dsp38_mac_sequencer #(.NUM_TAPS(4), .DSP_LATENCY(1)) u4 (
        .CLK(CLK), .RESET(RESET),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_sub(s_sub),
        .m_valid(m_valid), .m_ready(m_ready), .m_z(m_z), .busy(busy),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_load_acc(dsp_load_acc),
        .dsp_subtract(dsp_subtract), .dsp_feedback(dsp_feedback),
        .dsp_shift_right(dsp_shift_right), .dsp_round(dsp_round),
        .dsp_saturate(dsp_saturate), .dsp_z(dsp_z)
    );

    dsp38_mac_sequencer #(.NUM_TAPS(1), .DSP_LATENCY(1)) u1 (
        .CLK(CLK), .RESET(RESET),
        .s_valid(u1_s_valid), .s_ready(u1_s_ready), .s_a(u1_s_a), .s_b(u1_s_b),
        .s_sub(u1_s_sub), .m_valid(u1_m_valid), .m_ready(u1_m_ready), .m_z(u1_m_z),
        .busy(u1_busy), .dsp_a(u1_dsp_a), .dsp_b(u1_dsp_b),
        .dsp_load_acc(u1_dsp_load_acc), .dsp_subtract(u1_dsp_subtract),
        .dsp_feedback(u1_dsp_feedback), .dsp_shift_right(u1_dsp_shift_right),
        .dsp_round(u1_dsp_round), .dsp_saturate(u1_dsp_saturate), .dsp_z(u1_dsp_z)
    );

    // Behavioural DSP38 loads: signed 20x18 product, LOAD_ACC restarts the
    // sum, SUBTRACT negates the product, Z is registered (REGOUT only).
    logic [37:0] prod4, term4, prod1, term1;

    always_comb begin
        prod4 = 38'($signed(dsp_a)) * 38'($signed(dsp_b));
        term4 = dsp_subtract ? (38'd0 - prod4) : prod4;
        prod1 = 38'($signed(u1_dsp_a)) * 38'($signed(u1_dsp_b));
        term1 = u1_dsp_subtract ? (38'd0 - prod1) : prod1;
    end

    always @(posedge CLK) begin
        dsp_z    <= dsp_load_acc    ? term4 : dsp_z + term4;
        u1_dsp_z <= u1_dsp_load_acc ? term1 : u1_dsp_z + term1;
    end

    // One comparison: counts the vector and reports any miscompare.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one operand pair to u4 (called at a negedge), wait for it to be
    // taken, then check what was presented to the DSP.
    task automatic applyStimulus(input logic [19:0] a, input logic [17:0] b,
                                 input logic sub, input logic expLoad, input string tag);
        int n = 0;
        s_a = a; s_b = b; s_sub = sub; s_valid = 1'b1;
        while (!s_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        checkOutput({tag, "_rdy"}, 64'(s_ready), 64'd1);
        @(negedge CLK);
        s_valid = 1'b0; s_sub = 1'b0;
        checkOutput({tag, "_load"}, 64'(dsp_load_acc), 64'(expLoad));
        checkOutput({tag, "_a"},    64'(dsp_a), 64'(a));
        checkOutput({tag, "_b"},    64'(dsp_b), 64'(b));
        checkOutput({tag, "_sub"},  64'(dsp_subtract), 64'(sub));
        checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
    endtask

    // Called right after the last beat: expects m_valid two cycles later.
    task automatic waitResult(input logic [37:0] expZ, input string tag);
        int n = 0;
        checkOutput({tag, "_drain_rdy"}, 64'(s_ready), 64'd0);
        while (!m_valid && n < 20) begin
            @(negedge CLK);
            n++;
        end
        checkOutput({tag, "_lat"},  64'(n), 64'd2);
        checkOutput({tag, "_z"},    64'(m_z), 64'(expZ));
        checkOutput({tag, "_hbusy"}, 64'(busy), 64'd1);
    endtask

    // With m_ready high the result leaves after one cycle.
    task automatic finishResult(input string tag);
        @(negedge CLK);
        checkOutput({tag, "_mv_lo"}, 64'(m_valid), 64'd0);
        checkOutput({tag, "_rdy_hi"}, 64'(s_ready), 64'd1);
        checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        RESET = 1'b0;
        s_valid = 1'b0; s_a = '0; s_b = '0; s_sub = 1'b0; m_ready = 1'b1;
        u1_s_valid = 1'b0; u1_s_a = '0; u1_s_b = '0; u1_s_sub = 1'b0; u1_m_ready = 1'b1;
        repeat (3) @(negedge CLK);

        // Reset values.
        checkOutput("rst_rdy",  64'(s_ready), 64'd1);
        checkOutput("rst_mv",   64'(m_valid), 64'd0);
        checkOutput("rst_mz",   64'(m_z), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_a",    64'(dsp_a), 64'd0);
        checkOutput("rst_b",    64'(dsp_b), 64'd0);
        checkOutput("rst_load", 64'(dsp_load_acc), 64'd0);
        checkOutput("rst_sub",  64'(dsp_subtract), 64'd0);
        checkOutput("rst_fb",   64'(dsp_feedback), 64'd0);
        checkOutput("rst_shr",  64'(dsp_shift_right), 64'd0);
        checkOutput("rst_rnd",  64'(dsp_round), 64'd0);
        checkOutput("rst_sat",  64'(dsp_saturate), 64'd0);
        RESET = 1'b1;
        @(negedge CLK);
        checkOutput("post_rst_rdy", 64'(s_ready), 64'd1);

        // Test 1: 1*1 + 2*3 + 4*5 + (-1)*7 = 20.
        applyStimulus(20'd1, 18'd1, 1'b0, 1'b1, "t1_0");
        applyStimulus(20'd2, 18'd3, 1'b0, 1'b0, "t1_1");
        applyStimulus(20'd4, 18'd5, 1'b0, 1'b0, "t1_2");
        applyStimulus(20'hFFFFF, 18'd7, 1'b0, 1'b0, "t1_3");
        waitResult(38'd20, "t1");
        finishResult("t1");

        // Test 2: back-to-back groups, no carry-over between them.
        for (int i = 0; i < 4; i++) applyStimulus(20'd3, 18'd3, 1'b0, (i == 0), "t2a");
        waitResult(38'd36, "t2a");
        finishResult("t2a");
        for (int i = 0; i < 4; i++) applyStimulus(20'd1, 18'd2, 1'b0, (i == 0), "t2b");
        waitResult(38'd8, "t2b");
        finishResult("t2b");

        // Test 3: consumer stalls for 10 cycles; operands offered meanwhile
        // must not be taken.
        m_ready = 1'b0;
        applyStimulus(20'd1, 18'd1, 1'b0, 1'b1, "t3_0");
        applyStimulus(20'd2, 18'd3, 1'b0, 1'b0, "t3_1");
        applyStimulus(20'd4, 18'd5, 1'b0, 1'b0, "t3_2");
        applyStimulus(20'hFFFFF, 18'd7, 1'b0, 1'b0, "t3_3");
        waitResult(38'd20, "t3");
        s_valid = 1'b1; s_a = 20'd9; s_b = 18'd9;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            checkOutput("t3_hold_mv",  64'(m_valid), 64'd1);
            checkOutput("t3_hold_z",   64'(m_z), 64'd20);
            checkOutput("t3_hold_rdy", 64'(s_ready), 64'd0);
            checkOutput("t3_hold_a",   64'(dsp_a), 64'd0);
        end
        m_ready = 1'b1;
        @(negedge CLK);
        s_valid = 1'b0;
        checkOutput("t3_after_mv",  64'(m_valid), 64'd0);
        checkOutput("t3_after_rdy", 64'(s_ready), 64'd1);
        checkOutput("t3_after_a",   64'(dsp_a), 64'd0);
        checkOutput("t3_after_busy", 64'(busy), 64'd0);

        // Test 4: random idle gaps between taps, same sum as Test 1.
        begin
            logic [19:0] ta [4] = '{20'd1, 20'd2, 20'd4, 20'hFFFFF};
            logic [17:0] tb [4] = '{18'd1, 18'd3, 18'd5, 18'd7};
            for (int i = 0; i < 4; i++) begin
                int gap = $urandom_range(0, 3);
                if (i > 0 && gap > 0) begin
                    repeat (gap) @(negedge CLK);
                    checkOutput("t4_gap_a",    64'(dsp_a), 64'd0);
                    checkOutput("t4_gap_load", 64'(dsp_load_acc), 64'd0);
                end
                applyStimulus(ta[i], tb[i], 1'b0, (i == 0), "t4");
            end
        end
        waitResult(38'd20, "t4");
        checkOutput("t4_pre_rst_mz", 64'(m_z), 64'd20);

        // Test 5: reset mid-group, then a clean group of (2,2)x4 = 16.
        @(negedge CLK);
        applyStimulus(20'd1, 18'd1, 1'b0, 1'b1, "t5p0");
        applyStimulus(20'd2, 18'd3, 1'b0, 1'b0, "t5p1");
        RESET = 1'b0;
        #1;
        checkOutput("t5_rst_rdy",  64'(s_ready), 64'd1);
        checkOutput("t5_rst_busy", 64'(busy), 64'd0);
        checkOutput("t5_rst_a",    64'(dsp_a), 64'd0);
        checkOutput("t5_rst_mz",   64'(m_z), 64'd0);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < 4; i++) applyStimulus(20'd2, 18'd2, 1'b0, (i == 0), "t5");
        waitResult(38'd16, "t5");
        finishResult("t5");

        // Test 6a: subtract on tap 2: 1 - 6 + 20 - 7 = 8.
        applyStimulus(20'd1, 18'd1, 1'b0, 1'b1, "t6_0");
        applyStimulus(20'd2, 18'd3, 1'b1, 1'b0, "t6_1");
        applyStimulus(20'd4, 18'd5, 1'b0, 1'b0, "t6_2");
        applyStimulus(20'hFFFFF, 18'd7, 1'b0, 1'b0, "t6_3");
        waitResult(38'd8, "t6");
        finishResult("t6");

        // Test 6b: NUM_TAPS=1, 5 * -6 = -30 sign-extended to 38 bits.
        checkOutput("t6u_rdy0", 64'(u1_s_ready), 64'd1);
        u1_s_a = 20'd5; u1_s_b = 18'h3FFFA; u1_s_valid = 1'b1;
        @(negedge CLK);
        u1_s_valid = 1'b0;
        checkOutput("t6u_load", 64'(u1_dsp_load_acc), 64'd1);
        checkOutput("t6u_b",    64'(u1_dsp_b), 64'h3FFFA);
        checkOutput("t6u_rdy1", 64'(u1_s_ready), 64'd0);
        checkOutput("t6u_busy", 64'(u1_busy), 64'd1);
        @(negedge CLK);
        checkOutput("t6u_mv0",  64'(u1_m_valid), 64'd0);
        @(negedge CLK);
        checkOutput("t6u_mv1",  64'(u1_m_valid), 64'd1);
        checkOutput("t6u_z",    64'(u1_m_z), 64'h3FFFFFFFE2);
        @(negedge CLK);
        checkOutput("t6u_mv2",  64'(u1_m_valid), 64'd0);
        checkOutput("t6u_rdy2", 64'(u1_s_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

    // Hard bound in case a handshake never completes.
    initial begin
        #200000;
        $display("[TB] FAIL timeout vectors=%0d", nVec);
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
